// File: rtl/code_lock_ctrl.sv
// Keypad code lock: key edge detection, 4-digit entry, compare against CODE,
// failed-attempt counting and a tick-timed lockout.
module code_lock_ctrl #(
  parameter logic [15:0] CODE       = 16'h1234,
  parameter int          MAX_TRIES  = 5,
  parameter int          TICK_DIV   = 999_999,
  parameter int          LOCK_TICKS = 500
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] key_deb,
  output logic [15:0] disp_code,
  output logic [2:0]  digit_cnt,
  output logic [7:0]  tries,
  output logic        unlocked,
  output logic        locked_out
);

  localparam int PW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam int TW = (LOCK_TICKS > 1) ? $clog2(LOCK_TICKS + 1) : 1;

  typedef enum logic [1:0] {ENTRY, OPEN, LOCK} state_t;

  state_t        state_reg;
  logic [15:0]   key_prev_reg;
  logic [PW-1:0] presc_reg;
  logic [TW-1:0] lock_timer_reg;

  logic          tick;
  logic [15:0]   press;
  logic [15:0]   first_hot;
  logic [16:0]   seen;
  logic [3:0]    ev_key;
  logic          ev_valid;
  logic          is_digit;
  logic          is_clear;
  logic          is_enter;
  logic [7:0]    tries_inc;

  assign press   = key_deb & ~key_prev_reg;
  assign seen[0] = 1'b0;

  // Lowest-index rising key wins; simultaneous higher keys are dropped.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_prio
      assign first_hot[gi] = press[gi] & ~seen[gi];
      assign seen[gi+1]    = seen[gi] | press[gi];
    end
  endgenerate

  always_comb begin
    ev_key = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (first_hot[i]) ev_key = ev_key | 4'(i);
    end
  end

  assign ev_valid  = seen[16];
  assign is_digit  = ev_valid && (ev_key <= 4'd13);
  assign is_clear  = ev_valid && (ev_key == 4'd14);
  assign is_enter  = ev_valid && (ev_key == 4'd15);
  assign tries_inc = tries + 8'd1;
  assign tick      = (presc_reg == PW'(TICK_DIV));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= ENTRY;
      key_prev_reg   <= 16'hFFFF;
      lock_timer_reg <= '0;
      disp_code      <= 16'h0000;
      digit_cnt      <= 3'd0;
      tries          <= 8'd0;
      unlocked       <= 1'b0;
      locked_out     <= 1'b0;
    end else begin
      key_prev_reg <= key_deb;
      case (state_reg)
        ENTRY: begin
          if (is_digit && digit_cnt < 3'd4) begin
            disp_code <= {disp_code[11:0], ev_key};
            digit_cnt <= digit_cnt + 3'd1;
          end else if (is_clear) begin
            disp_code <= 16'h0000;
            digit_cnt <= 3'd0;
          end else if (is_enter && digit_cnt == 3'd4) begin
            disp_code <= 16'h0000;
            digit_cnt <= 3'd0;
            if (disp_code == CODE) begin
              state_reg <= OPEN;
              tries     <= 8'd0;
              unlocked  <= 1'b1;
            end else begin
              tries <= tries_inc;
              if (tries_inc == 8'(MAX_TRIES)) begin
                state_reg      <= LOCK;
                lock_timer_reg <= TW'(LOCK_TICKS);
                locked_out     <= 1'b1;
              end
            end
          end
        end
        OPEN: begin
          if (is_clear) begin
            state_reg <= ENTRY;
            unlocked  <= 1'b0;
          end
        end
        LOCK: begin
          // Key events are swallowed here; only the prescaler tick matters.
          if (tick) begin
            if (lock_timer_reg == TW'(1)) begin
              state_reg      <= ENTRY;
              tries          <= 8'd0;
              lock_timer_reg <= '0;
              locked_out     <= 1'b0;
            end else begin
              lock_timer_reg <= lock_timer_reg - TW'(1);
            end
          end
        end
        default: begin
          state_reg  <= ENTRY;
          unlocked   <= 1'b0;
          locked_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Self-checking bench for code_lock_ctrl: directed scenarios plus random key
// traffic, compared every cycle against a queue-based behavioural model.
module tb_code_lock_ctrl;

  localparam int          TICK_DIV   = 3;
  localparam int          LOCK_TICKS = 2;
  localparam int          MAX_TRIES  = 5;
  localparam logic [15:0] CODE       = 16'h1234;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] key_deb = 16'h0000;
  logic [15:0] disp_code;
  logic [2:0]  digit_cnt;
  logic [7:0]  tries;
  logic        unlocked;
  logic        locked_out;

  int errors = 0;
  int checks = 0;

  code_lock_ctrl #(
    .CODE(CODE), .MAX_TRIES(MAX_TRIES), .TICK_DIV(TICK_DIV), .LOCK_TICKS(LOCK_TICKS)
  ) dut (
    .clk(clk), .rstn(rstn), .key_deb(key_deb), .disp_code(disp_code),
    .digit_cnt(digit_cnt), .tries(tries), .unlocked(unlocked), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=entry 1=open 2=lockout, digits kept as a queue.
  int          m_mode;
  int          m_digits[$];
  int          m_tries;
  int          m_timer;
  int          m_pcnt;
  logic [15:0] m_prev;

  function automatic logic [15:0] m_disp();
    int d = 0;
    foreach (m_digits[i]) d = (d << 4) | m_digits[i];
    return 16'(d);
  endfunction

  task automatic m_reset();
    m_mode = 0;
    m_digits.delete();
    m_tries = 0;
    m_timer = 0;
    m_pcnt  = 0;
    m_prev  = 16'hFFFF;
  endtask

  task automatic m_step();
    logic [15:0] pr;
    int          k;
    bit          t;
    pr     = key_deb & ~m_prev;
    m_prev = key_deb;
    t      = (m_pcnt == TICK_DIV);
    m_pcnt = (m_pcnt + 1) % (TICK_DIV + 1);
    k = -1;
    for (int i = 15; i >= 0; i--) if (pr[i]) k = i;
    case (m_mode)
      0: begin
        if (k >= 0 && k <= 13) begin
          if (m_digits.size() < 4) m_digits.push_back(k);
        end else if (k == 14) begin
          m_digits.delete();
        end else if (k == 15 && m_digits.size() == 4) begin
          if (m_disp() == CODE) begin
            m_mode  = 1;
            m_tries = 0;
          end else begin
            m_tries++;
            if (m_tries == MAX_TRIES) begin
              m_mode  = 2;
              m_timer = LOCK_TICKS;
            end
          end
          m_digits.delete();
        end
      end
      1: if (k == 14) m_mode = 0;
      default: begin
        if (t) begin
          m_timer--;
          if (m_timer == 0) begin
            m_mode  = 0;
            m_tries = 0;
          end
        end
      end
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) m_reset();
      else m_step();
    end
  end

  initial begin
    @(negedge clk);
    forever begin
      @(negedge clk);
      chk("disp_code", disp_code, m_disp());
      chk("digit_cnt", digit_cnt, m_digits.size());
      chk("tries", tries, m_tries);
      chk("unlocked", unlocked, m_mode == 1);
      chk("locked_out", locked_out, m_mode == 2);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k);
    @(negedge clk);
    key_deb = 16'(1) << k;
    @(negedge clk);
    key_deb = 16'h0000;
    $display("key %0d: disp_code=%h digit_cnt=%0d tries=%0d unlocked=%0b locked_out=%0b",
             k, disp_code, digit_cnt, tries, unlocked, locked_out);
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(int'(c[4*i +: 4]));
    press(15);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_disp"}, disp_code, 16'h0000);
    chk({tag, "_cnt"}, digit_cnt, 3'd0);
    chk({tag, "_tries"}, tries, 8'd0);
    chk({tag, "_unlocked"}, unlocked, 1'b0);
    chk({tag, "_locked"}, locked_out, 1'b0);
  endtask

  initial begin
    int          n;
    int          r;
    int          keys[7] = '{1, 2, 3, 4, 5, 14, 15};
    logic [15:0] c;

    cyc(2);
    reset_vals("reset");
    rstn = 1'b1;
    cyc(2);

    // 1: correct code opens, CLEAR relocks
    press(1); press(2); press(3); press(4);
    chk("s1_disp", disp_code, 16'h1234);
    chk("s1_cnt", digit_cnt, 3'd4);
    press(15);
    chk("s1_unlocked", unlocked, 1'b1);
    chk("s1_tries", tries, 8'd0);
    chk("s1_cnt_after", digit_cnt, 3'd0);
    press(14);
    chk("s1_closed", unlocked, 1'b0);

    // 2: wrong code counts, right code resets count
    enter_code(16'h1235);
    chk("s2_tries", tries, 8'd1);
    chk("s2_disp", disp_code, 16'h0000);
    chk("s2_unlocked", unlocked, 1'b0);
    enter_code(CODE);
    chk("s2_tries_reset", tries, 8'd0);
    chk("s2_unlocked2", unlocked, 1'b1);
    press(14);

    // 3: lockout after five failures, then timed release
    repeat (5) enter_code(16'h1235);
    chk("s3_locked", locked_out, 1'b1);
    chk("s3_tries", tries, 8'd5);
    press(7);
    chk("s3_disp_locked", disp_code, 16'h0000);
    n = 2;
    while (locked_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < 5 || n > 8) begin
      errors++;
      $display("FAIL lock_duration: got %0d cycles required 5..8", n);
    end
    chk("s3_released", locked_out, 1'b0);
    chk("s3_tries_clr", tries, 8'd0);

    // 4: simultaneous rise takes lowest key; a held key yields one event
    @(negedge clk);
    key_deb = 16'h0088;
    @(negedge clk);
    chk("s4_disp", disp_code, 16'h0003);
    key_deb = 16'h0008;
    cyc(100);
    chk("s4_disp_held", disp_code, 16'h0003);
    chk("s4_cnt_held", digit_cnt, 3'd1);
    key_deb = 16'h0000;
    press(14);

    // 5: fifth digit ignored, short ENTER ignored
    press(1); press(2); press(3); press(4); press(5);
    chk("s5_disp", disp_code, 16'h1234);
    chk("s5_cnt", digit_cnt, 3'd4);
    press(14);
    chk("s5_clear", disp_code, 16'h0000);
    press(1); press(2); press(15);
    chk("s5_short_disp", disp_code, 16'h0012);
    chk("s5_short_tries", tries, 8'd0);
    press(14);

    // 6: async reset during lockout with a key held
    repeat (5) enter_code(16'h1235);
    chk("s6_locked", locked_out, 1'b1);
    @(negedge clk);
    key_deb = 16'h0010;
    cyc(3);
    #1 rstn = 1'b0;
    #1 reset_vals("s6_async");
    cyc(3);
    rstn = 1'b1;
    cyc(5);
    chk("s6_no_event_disp", disp_code, 16'h0000);
    chk("s6_no_event_cnt", digit_cnt, 3'd0);
    key_deb = 16'h0000;
    cyc(2);
    press(4);
    chk("s6_repress", disp_code, 16'h0004);
    press(14);

    // Random traffic checked by the per-cycle compare
    repeat (300) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        press(keys[$urandom_range(0, 6)]);
      end else if (r == 5) begin
        enter_code(CODE);
      end else if (r == 6) begin
        c = {4'($urandom_range(1, 5)), 4'($urandom_range(1, 5)),
             4'($urandom_range(1, 5)), 4'($urandom_range(1, 5))};
        enter_code(c);
      end else if (r == 7) begin
        @(negedge clk);
        key_deb = 16'($urandom());
        @(negedge clk);
        key_deb = 16'h0000;
      end else begin
        cyc($urandom_range(1, 6));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Keypad code-lock controller for the display board's 16-key pad. It consumes the debounced, active-high key levels produced by the key debouncer and turns rising edges into single key events. It sequences a 4-digit code entry, compares the entry against a stored code, counts failed attempts and enforces a timed lockout. Its outputs drive the seven-segment display and the status LEDs.

## Interface
- CODE, 16'h1234: unlock code as four hex digits, most significant digit entered first; each digit must be ≤ 4'hD.
- MAX_TRIES, 5: number of failed attempts that triggers lockout; legal range 1..255.
- TICK_DIV, 999_999: prescaler terminal count; one tick every TICK_DIV+1 clk cycles (20 ms at 50 MHz).
- LOCK_TICKS, 500: lockout duration in ticks; must be ≥ 1.
- clk  in  1  system clock; the block uses a single clock.
- rstn  in  1  asynchronous, active-low reset.
- key_deb  in  16  debounced key levels; 1 = pressed. Bit i is key i.
- disp_code  out  16  digits entered so far, newest digit in [3:0].
- digit_cnt  out  3  number of digits entered, 0..4.
- tries  out  8  count of consecutive failed attempts.
- unlocked  out  1  high while in OPEN.
- locked_out  out  1  high while in LOCK.

## Operation
- Key map:
  - Keys 0..13 are digits 0x0..0xD.
  - Key 14 is CLEAR.
  - Key 15 is ENTER.
- Edge detection:
  - key_prev <= key_deb every cycle.
  - A press event is defined as key_deb & ~key_prev.
  - If several bits rise in the same cycle, only the lowest index is acted on; the others are discarded, because key_prev still absorbs them.
  - A held key produces exactly one event.
- Prescaler: free-running counter 0..TICK_DIV, wrapping to 0. tick is asserted for one cycle when the counter equals TICK_DIV.
- State machine (ENTRY, OPEN, LOCK), reset to ENTRY.
- ENTRY:
  - Digit event with digit_cnt < 4: disp_code <= {disp_code[11:0], d} and digit_cnt + 1.
  - Digit event with digit_cnt == 4: ignored.
  - CLEAR: disp_code <= 0, digit_cnt <= 0.
  - ENTER with digit_cnt < 4: ignored; no attempt is counted.
  - ENTER with digit_cnt == 4 and disp_code == CODE: go to OPEN, tries <= 0, entry cleared.
  - ENTER with digit_cnt == 4 and a mismatch: entry cleared, tries <= tries + 1. If tries + 1 == MAX_TRIES, go to LOCK and load lock_timer <= LOCK_TICKS.
- OPEN:
  - CLEAR returns to ENTRY; tries stays 0.
  - All other events are ignored.
- LOCK:
  - All key events are ignored; key_prev still tracks key_deb.
  - On each tick, lock_timer decrements.
  - A tick with lock_timer == 1 moves the block to ENTRY with tries <= 0 and lock_timer <= 0.
- Width rules:
  - lock_timer must be wide enough for LOCK_TICKS.
  - tries never exceeds MAX_TRIES because lockout triggers first, so no wrap is possible.

## Timing
- Reset values:
  - state ENTRY; disp_code 16'h0000; digit_cnt 0; tries 0; unlocked 0; locked_out 0.
  - key_prev 16'hFFFF, so keys held across reset release produce no event.
  - Prescaler 0; lock_timer 0.
- Latency:
  - key_deb is first sampled high at edge k; the event is processed at edge k.
  - All outputs show the result from edge k onward, one cycle after the key level change.
- unlocked and locked_out are registered and decoded from state, with no combinational path from key_deb.
- Lockout duration:
  - From entry into LOCK to return to ENTRY lasts between LOCK_TICKS-1 and LOCK_TICKS tick periods, because the prescaler is not realigned on entry.
  - A tick in the same cycle as the failing ENTER does not decrement the freshly loaded timer.
- Reset asserted mid-operation (any state, any timer value) forces all reset values asynchronously. The prescaler restarts from 0.

## Test plan
- Bench parameters: TICK_DIV=3, LOCK_TICKS=2, MAX_TRIES=5, CODE=16'h1234.
1. Press 1,2,3,4, then ENTER, each as a single-cycle rising edge -> disp_code 16'h1234 and digit_cnt 4 before ENTER; one cycle after ENTER: unlocked=1, tries=0, digit_cnt=0. CLEAR then returns unlocked=0.
2. Press 1,2,3,5, ENTER -> tries=1, disp_code=0, unlocked=0. A subsequent correct code resets tries to 0.
3. Five wrong entries -> locked_out=1 after the 5th ENTER with tries=5. Digits pressed during LOCK leave disp_code=0. After 2 ticks (≤ 8 cycles): locked_out=0, tries=0, state ENTRY.
4. key_deb bits 3 and 7 rise in the same cycle -> only digit 3 is shifted in (disp_code=16'h0003). Holding key 3 for 100 cycles adds no further digits.
5. Enter 1,2,3,4,5 -> 5 is ignored and disp_code=16'h1234. CLEAR -> 0. Enter 1,2 then ENTER -> ignored, tries unchanged.
6. Assert rstn low during LOCK while key 4 is held, then release -> all outputs at reset values and no digit event from key 4 until it is released and pressed again.
